// File: rtl/dcache_mem_bridge.sv
// Memory-side bridge for the data cache: serialises line/word reads and buffered
// writes into single-word request/grant transactions, one outstanding at a time.
module dcache_mem_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ram_rd_req_i,
  input  logic [2:0]              ram_rd_type_i,
  input  logic [ADDR_WIDTH-1:0]   ram_rd_addr_i,
  output logic                    ram_rd_rdy_o,
  output logic [DATA_WIDTH-1:0]   ram_rd_data_o,
  output logic                    ram_rd_valid_o,
  output logic [1:0]              ram_rd_last_o,
  input  logic                    ram_wr_req_i,
  input  logic [2:0]              ram_wr_type_i,
  input  logic [3:0]              ram_wr_en_i,
  input  logic [ADDR_WIDTH-1:0]   ram_wr_addr_i,
  input  logic [4*DATA_WIDTH-1:0] ram_wr_data_i,
  output logic                    ram_wr_rdy_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [3:0]              mem_wstrb_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
  localparam logic [2:0] T_LINE = 3'b100;

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;
  state_t state;

  logic                    wb_valid, wb_line;
  logic [3:0]              wb_mask;
  logic [ADDR_WIDTH-1:0]   wb_addr;
  logic [4*DATA_WIDTH-1:0] wb_data;
  logic                    rd_line;
  logic [ADDR_WIDTH-1:0]   base;
  logic [1:0]              beat_cnt, nb;

  logic rd_accept, wr_accept, rd_final, wr_final, rd_is_line;
  logic [ADDR_WIDTH-1:0] rd_base, next_addr;

  // Write launch source: the buffer if occupied, else the write being accepted now
  logic                  w_line;
  logic [3:0]            w_mask;
  logic [ADDR_WIDTH-1:0] w_addr, w_base;
  logic [DATA_WIDTH-1:0] w_word0;

  assign ram_wr_rdy_o = !wb_valid;
  assign ram_rd_rdy_o = (state == IDLE) && !wb_valid && !ram_wr_req_i;
  assign rd_accept    = ram_rd_req_i && ram_rd_rdy_o;
  assign wr_accept    = ram_wr_req_i && ram_wr_rdy_o;

  assign rd_is_line = (ram_rd_type_i == T_LINE);
  assign rd_base    = rd_is_line ? {ram_rd_addr_i[ADDR_WIDTH-1:4], 4'b0} : ram_rd_addr_i;

  assign w_line  = wb_valid ? wb_line : (ram_wr_type_i == T_LINE);
  assign w_mask  = wb_valid ? wb_mask : ram_wr_en_i;
  assign w_addr  = wb_valid ? wb_addr : ram_wr_addr_i;
  assign w_word0 = wb_valid ? wb_data[DATA_WIDTH-1:0] : ram_wr_data_i[DATA_WIDTH-1:0];
  assign w_base  = w_line ? {w_addr[ADDR_WIDTH-1:4], 4'b0} : w_addr;

  assign nb        = beat_cnt + 2'd1;
  assign next_addr = base + {{(ADDR_WIDTH-4){1'b0}}, nb, 2'b00};
  assign rd_final  = !rd_line || (beat_cnt == 2'd3);
  assign wr_final  = !wb_line || (beat_cnt == 2'd3);

  // Read return path is a pass-through, gated so nothing leaks outside RD_WAIT
  assign ram_rd_valid_o = (state == RD_WAIT) && mem_rvalid_i;
  assign ram_rd_data_o  = ram_rd_valid_o ? mem_rdata_i : '0;
  assign ram_rd_last_o  = {1'b0, ram_rd_valid_o && rd_final};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wb_valid    <= 1'b0;
      wb_line     <= 1'b0;
      wb_mask     <= '0;
      wb_addr     <= '0;
      wb_data     <= '0;
      rd_line     <= 1'b0;
      base        <= '0;
      beat_cnt    <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wstrb_o <= '0;
      mem_wdata_o <= '0;
    end else begin
      if (wr_accept) begin
        wb_valid <= 1'b1;
        wb_line  <= (ram_wr_type_i == T_LINE);
        wb_mask  <= ram_wr_en_i;
        wb_addr  <= ram_wr_addr_i;
        wb_data  <= ram_wr_data_i;
      end
      case (state)
        IDLE: begin
          if (rd_accept) begin
            rd_line     <= rd_is_line;
            base        <= rd_base;
            beat_cnt    <= '0;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= rd_base;
            mem_wstrb_o <= '0;
            state       <= RD_REQ;
          end else if (wb_valid || wr_accept) begin
            base        <= w_base;
            beat_cnt    <= '0;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b1;
            mem_addr_o  <= w_base;
            mem_wstrb_o <= w_line ? 4'hF : w_mask;
            mem_wdata_o <= w_word0;
            state       <= WR_REQ;
          end
        end
        RD_REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_rvalid_i) begin
            if (rd_final) begin
              state <= IDLE;
            end else begin
              beat_cnt   <= nb;
              mem_addr_o <= next_addr;
              mem_req_o  <= 1'b1;
              state      <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (mem_gnt_i) begin
            if (wr_final) begin
              wb_valid    <= 1'b0;
              mem_req_o   <= 1'b0;
              mem_we_o    <= 1'b0;
              mem_wstrb_o <= '0;
              state       <= IDLE;
            end else begin
              beat_cnt    <= nb;
              mem_addr_o  <= next_addr;
              mem_wdata_o <= wb_data[nb*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Directed bench for dcache_mem_bridge with a small grant/rvalid memory responder.
`timescale 1ns/1ps
module tb_dcache_mem_bridge;
  logic         clk = 0;
  logic         rst = 1;
  logic         rd_req = 0;
  logic [2:0]   rd_type = 0;
  logic [31:0]  rd_addr = 0;
  logic         ram_rd_rdy_o, ram_rd_valid_o;
  logic [31:0]  ram_rd_data_o;
  logic [1:0]   ram_rd_last_o;
  logic         wr_req = 0;
  logic [2:0]   wr_type = 0;
  logic [3:0]   wr_en = 0;
  logic [31:0]  wr_addr = 0;
  logic [127:0] wr_data = 0;
  logic         ram_wr_rdy_o;
  logic         mem_req_o, mem_we_o;
  logic [31:0]  mem_addr_o, mem_wdata_o;
  logic [3:0]   mem_wstrb_o;
  logic         mem_gnt_i = 0, mem_rvalid_i = 0;
  logic [31:0]  mem_rdata_i = 0;

  int tests = 0, fails = 0;
  int cyc = 0;

  dcache_mem_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ram_rd_req_i(rd_req), .ram_rd_type_i(rd_type), .ram_rd_addr_i(rd_addr),
    .ram_rd_rdy_o(ram_rd_rdy_o), .ram_rd_data_o(ram_rd_data_o),
    .ram_rd_valid_o(ram_rd_valid_o), .ram_rd_last_o(ram_rd_last_o),
    .ram_wr_req_i(wr_req), .ram_wr_type_i(wr_type), .ram_wr_en_i(wr_en),
    .ram_wr_addr_i(wr_addr), .ram_wr_data_i(wr_data), .ram_wr_rdy_o(ram_wr_rdy_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder + read-return monitor
  int gnt_delay = 0, rv_delay = 1, stall = 0, rv_cnt = 0, stab_err = 0;
  int first_req = -1, last_valid = -1;
  logic [31:0] rv_data, held_addr, held_wdata;
  logic [31:0] log_addr[$], log_wdata[$], rd_data_q[$];
  logic        log_we[$];
  logic [3:0]  log_strb[$];
  logic [1:0]  rd_last_q[$];

  always @(negedge clk) begin
    mem_gnt_i = 0;
    mem_rvalid_i = 0;
    if (rst) begin
      rv_cnt = 0;
      stall = 0;
    end else begin
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin mem_rvalid_i = 1; mem_rdata_i = rv_data; end
      end
      if (mem_req_o) begin
        if (first_req < 0) first_req = cyc;
        if (stall == 0) begin
          held_addr = mem_addr_o; held_wdata = mem_wdata_o;
        end else if (mem_addr_o !== held_addr || mem_wdata_o !== held_wdata) stab_err++;
        if (stall >= gnt_delay) begin
          mem_gnt_i = 1;
          stall = 0;
          log_addr.push_back(mem_addr_o); log_we.push_back(mem_we_o);
          log_strb.push_back(mem_wstrb_o); log_wdata.push_back(mem_wdata_o);
          if (!mem_we_o) begin
            rv_cnt = rv_delay;
            rv_data = (mem_addr_o == 32'h1000_0008) ? 32'hDEAD_BEEF : {16'hC0DE, mem_addr_o[15:0]};
          end
        end else stall++;
      end
    end
    #2;
    if (ram_rd_valid_o) begin
      rd_data_q.push_back(ram_rd_data_o);
      rd_last_q.push_back(ram_rd_last_o);
      last_valid = cyc;
    end
  end

  task automatic clear_logs();
    log_addr.delete(); log_we.delete(); log_strb.delete(); log_wdata.delete();
    rd_data_q.delete(); rd_last_q.delete();
    first_req = -1; last_valid = -1; stab_err = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rd(input int n);
    for (int i = 0; i < 300 && rd_data_q.size() < n; i++) begin @(negedge clk); #3; end
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 300 && log_addr.size() < n; i++) begin @(negedge clk); #3; end
  endtask

  task automatic do_read(input logic [2:0] t, input logic [31:0] a, output int acc, output bit ok);
    @(negedge clk);
    rd_type = t; rd_addr = a; rd_req = 1; ok = 0; acc = -1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (ram_rd_rdy_o) begin ok = 1; acc = cyc; break; end
      @(negedge clk);
    end
    @(posedge clk); #1 rd_req = 0;
  endtask

  task automatic do_write(input logic [2:0] t, input logic [3:0] m, input logic [31:0] a,
                          input logic [127:0] d, output bit ok);
    @(negedge clk);
    wr_type = t; wr_en = m; wr_addr = a; wr_data = d; wr_req = 1; ok = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (ram_wr_rdy_o) begin ok = 1; break; end
      @(negedge clk);
    end
    @(posedge clk); #1 wr_req = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    tests++; if (mem_req_o !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", mem_req_o); end
    tests++; if (mem_we_o !== 1'b0) begin fails++; $display("FAIL reset_we got %b want 0", mem_we_o); end
    tests++; if (mem_wstrb_o !== 4'h0) begin fails++; $display("FAIL reset_wstrb got %h want 0", mem_wstrb_o); end
    tests++; if (mem_addr_o !== 32'h0) begin fails++; $display("FAIL reset_addr got %h want 0", mem_addr_o); end
    tests++; if (mem_wdata_o !== 32'h0) begin fails++; $display("FAIL reset_wdata got %h want 0", mem_wdata_o); end
    tests++; if (ram_rd_valid_o !== 1'b0) begin fails++; $display("FAIL reset_rvalid got %b want 0", ram_rd_valid_o); end
    tests++; if (ram_rd_last_o !== 2'b00) begin fails++; $display("FAIL reset_last got %b want 00", ram_rd_last_o); end
    tests++; if (ram_rd_data_o !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", ram_rd_data_o); end
    tests++; if (ram_rd_rdy_o !== 1'b1) begin fails++; $display("FAIL reset_rd_rdy got %b want 1", ram_rd_rdy_o); end
    tests++; if (ram_wr_rdy_o !== 1'b1) begin fails++; $display("FAIL reset_wr_rdy got %b want 1", ram_wr_rdy_o); end
    idle(2);
    rst = 0;
    idle(2);
  endtask

  task automatic test_word_read();
    int acc; bit ok;
    clear_logs(); gnt_delay = 0; rv_delay = 3;
    do_read(3'b010, 32'h1000_0008, acc, ok);
    wait_rd(1);
    tests++; if (!ok || rd_data_q.size() != 1) begin fails++; $display("FAIL word_rd_count got %0d want 1", rd_data_q.size()); end
    else begin
      tests++; if (rd_data_q[0] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL word_rd_data got %h want deadbeef", rd_data_q[0]); end
      tests++; if (rd_last_q[0] !== 2'b01) begin fails++; $display("FAIL word_rd_last got %b want 01", rd_last_q[0]); end
    end
    tests++; if (first_req - acc != 1) begin fails++; $display("FAIL word_rd_latency got %0d want 1", first_req - acc); end
    tests++; if (log_addr.size() != 1 || log_addr[0] !== 32'h1000_0008 || log_we[0] !== 1'b0 || log_strb[0] !== 4'h0)
      begin fails++; $display("FAIL word_rd_beat got n=%0d addr=%h want 1 beat at 10000008", log_addr.size(), log_addr.size() ? log_addr[0] : 32'h0); end
    @(negedge clk); #1;
    tests++; if (ram_rd_rdy_o !== 1'b1) begin fails++; $display("FAIL word_rd_rdy_after got %b want 1", ram_rd_rdy_o); end
    idle(4);
    tests++; if (rd_data_q.size() != 1) begin fails++; $display("FAIL word_rd_extra got %0d want 1", rd_data_q.size()); end
  endtask

  task automatic test_line_read();
    int acc; bit ok;
    logic [31:0] ea [4];
    logic [31:0] ed [4];
    ea = '{32'h2000_0010, 32'h2000_0014, 32'h2000_0018, 32'h2000_001C};
    ed = '{32'hC0DE_0010, 32'hC0DE_0014, 32'hC0DE_0018, 32'hC0DE_001C};
    clear_logs(); gnt_delay = 0; rv_delay = 1;
    do_read(3'b100, 32'h2000_0014, acc, ok);
    wait_rd(4);
    idle(3);
    tests++; if (!ok || rd_data_q.size() != 4 || log_addr.size() != 4) begin
      fails++; $display("FAIL line_rd_count got %0d beats %0d grants want 4", rd_data_q.size(), log_addr.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests++; if (log_addr[k] !== ea[k]) begin fails++; $display("FAIL line_rd_addr%0d got %h want %h", k, log_addr[k], ea[k]); end
        tests++; if (rd_data_q[k] !== ed[k]) begin fails++; $display("FAIL line_rd_data%0d got %h want %h", k, rd_data_q[k], ed[k]); end
        tests++; if (rd_last_q[k] !== ((k == 3) ? 2'b01 : 2'b00))
          begin fails++; $display("FAIL line_rd_last%0d got %b want %b", k, rd_last_q[k], (k == 3) ? 2'b01 : 2'b00); end
      end
    end
    tests++; if (last_valid - first_req != 7) begin fails++; $display("FAIL line_rd_span got %0d want 7", last_valid - first_req); end
  endtask

  task automatic test_line_write();
    bit ok;
    logic [31:0] ea [4];
    logic [31:0] ed [4];
    ea = '{32'h3000_0020, 32'h3000_0024, 32'h3000_0028, 32'h3000_002C};
    ed = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    clear_logs(); gnt_delay = 2;
    do_write(3'b100, 4'h0, 32'h3000_0020, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, ok);
    wait_log(4);
    idle(3);
    tests++; if (!ok || log_addr.size() != 4) begin fails++; $display("FAIL line_wr_count got %0d want 4", log_addr.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        tests++; if (log_addr[k] !== ea[k] || log_we[k] !== 1'b1 || log_strb[k] !== 4'hF || log_wdata[k] !== ed[k])
          begin fails++; $display("FAIL line_wr_beat%0d got a=%h we=%b s=%h d=%h want a=%h we=1 s=f d=%h",
                                  k, log_addr[k], log_we[k], log_strb[k], log_wdata[k], ea[k], ed[k]); end
      end
    end
    tests++; if (stab_err != 0) begin fails++; $display("FAIL line_wr_hold got %0d changes want 0", stab_err); end
    tests++; if (ram_wr_rdy_o !== 1'b1 || mem_req_o !== 1'b0)
      begin fails++; $display("FAIL line_wr_done got wr_rdy=%b req=%b want 1 0", ram_wr_rdy_o, mem_req_o); end
    gnt_delay = 0;
  endtask

  task automatic test_conflict();
    bit ok = 0;
    int wlog = -1;
    clear_logs(); gnt_delay = 0; rv_delay = 1;
    @(negedge clk);
    rd_type = 3'b010; rd_addr = 32'h5000_0010; rd_req = 1;
    wr_type = 3'b010; wr_en = 4'hF; wr_addr = 32'h5000_0000; wr_data = {96'h0, 32'h1122_3344}; wr_req = 1;
    #1;
    tests++; if (ram_wr_rdy_o !== 1'b1 || ram_rd_rdy_o !== 1'b0)
      begin fails++; $display("FAIL conflict_rdy got wr=%b rd=%b want 1 0", ram_wr_rdy_o, ram_rd_rdy_o); end
    @(posedge clk); #1 wr_req = 0;
    @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      #1;
      if (ram_rd_rdy_o) begin ok = 1; wlog = log_addr.size(); break; end
      @(negedge clk);
    end
    @(posedge clk); #1 rd_req = 0;
    tests++; if (!ok || wlog != 1) begin fails++; $display("FAIL conflict_order got %0d writes before read accept want 1", wlog); end
    wait_rd(1);
    tests++; if (log_addr.size() != 2 || log_we[0] !== 1'b1 || log_addr[0] !== 32'h5000_0000 ||
                 log_wdata[0] !== 32'h1122_3344 || log_we[1] !== 1'b0 || log_addr[1] !== 32'h5000_0010)
      begin fails++; $display("FAIL conflict_seq got n=%0d want write 50000000 then read 50000010", log_addr.size()); end
    tests++; if (rd_data_q.size() != 1 || rd_data_q[0] !== 32'hC0DE_0010)
      begin fails++; $display("FAIL conflict_rdata got n=%0d want 1 beat c0de0010", rd_data_q.size()); end
    idle(2);
  endtask

  task automatic test_byte_write();
    bit ok;
    clear_logs(); gnt_delay = 1;
    do_write(3'b000, 4'b0100, 32'h4000_0002, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hCAFE_F00D}, ok);
    wait_log(1);
    idle(6);
    tests++; if (!ok || log_addr.size() != 1) begin fails++; $display("FAIL byte_wr_count got %0d want 1", log_addr.size()); end
    else begin
      tests++; if (log_addr[0] !== 32'h4000_0002 || log_strb[0] !== 4'b0100 || log_wdata[0] !== 32'hCAFE_F00D || log_we[0] !== 1'b1)
        begin fails++; $display("FAIL byte_wr_beat got a=%h s=%b d=%h want 40000002 0100 cafef00d", log_addr[0], log_strb[0], log_wdata[0]); end
    end
    tests++; if (stab_err != 0) begin fails++; $display("FAIL byte_wr_hold got %0d want 0", stab_err); end
    gnt_delay = 0;
  endtask

  task automatic test_reset_mid();
    int acc; bit ok;
    clear_logs(); gnt_delay = 0; rv_delay = 3;
    do_read(3'b100, 32'h6000_0000, acc, ok);
    wait_log(2);
    @(negedge clk); #1;
    rst = 1;
    #1;
    tests++; if (mem_req_o !== 1'b0 || ram_rd_valid_o !== 1'b0)
      begin fails++; $display("FAIL rstmid_out got req=%b valid=%b want 0 0", mem_req_o, ram_rd_valid_o); end
    tests++; if (ram_rd_rdy_o !== 1'b1) begin fails++; $display("FAIL rstmid_idle got rd_rdy=%b want 1", ram_rd_rdy_o); end
    idle(2);
    rst = 0;
    idle(4);
    tests++; if (rd_data_q.size() != 1) begin fails++; $display("FAIL rstmid_beats got %0d want 1", rd_data_q.size()); end
    clear_logs(); rv_delay = 1;
    do_read(3'b010, 32'h1000_0008, acc, ok);
    wait_rd(1);
    tests++; if (!ok || rd_data_q.size() != 1 || rd_data_q[0] !== 32'hDEAD_BEEF || log_addr.size() != 1)
      begin fails++; $display("FAIL rstmid_reread got n=%0d want one beat deadbeef", rd_data_q.size()); end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_line_read();
    test_line_write();
    test_conflict();
    test_byte_write();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
